// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
//
// Free pool of physical register indices for the out-of-order pipeline. It is
// organised as a circular FIFO. The rename stage takes up to two indices per
// cycle from the head. Allocation is all-or-nothing: either every request in
// the cycle is granted, or none is. The retire side returns up to two indices
// per cycle at the tail, slot 1 before slot 2.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous, active-high reset
//   alloc_req_1_i    rename slot 1 wants a destination preg
//   alloc_req_2_i    rename slot 2 wants a destination preg
//   alloc_grant_o    combinational: free count covers the number of requests
//   alloc_preg_1_o   combinational: preg offered to slot 1
//   alloc_preg_2_o   combinational: preg offered to slot 2
//   retire_flag_1_i  release fp_ind_1_i
//   fp_ind_1_i       preg released by slot 1
//   retire_flag_2_i  release fp_ind_2_i
//   fp_ind_2_i       preg released by slot 2
//   free_count_o     registered: number of free entries, 0..DEPTH
//   free_overflow_o  registered: sticky flag, set when a release was dropped
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       alloc_req_1_i,
   input  logic       alloc_req_2_i,
   output logic       alloc_grant_o,
   output logic [5:0] alloc_preg_1_o,
   output logic [5:0] alloc_preg_2_o,
   input  logic       retire_flag_1_i,
   input  logic [5:0] fp_ind_1_i,
   input  logic       retire_flag_2_i,
   input  logic [5:0] fp_ind_2_i,
   output logic [5:0] free_count_o,
   output logic       free_overflow_o
);

   localparam int PREG_W = 6;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = 6;
   localparam int SPC_W  = CNT_W + 1;

   localparam logic [SPC_W-1:0] SPC_DEPTH = SPC_W'(DEPTH);
   localparam logic [SPC_W-1:0] SPC_ONE   = SPC_W'(1);
   localparam logic [SPC_W-1:0] SPC_TWO   = SPC_W'(2);

   // Advance a FIFO pointer by 0..2 positions, wrapping modulo DEPTH.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0]       n);
      logic [PTR_W+1:0] sum;
      sum = {2'b00, p} + {{PTR_W{1'b0}}, n};
      if (sum >= (PTR_W+2)'(DEPTH)) begin
         sum = sum - (PTR_W+2)'(DEPTH);
      end else begin
         sum = sum;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Storage and state
   logic [PREG_W-1:0] entry_q [DEPTH];
   logic [PTR_W-1:0]  head_q,  head_d;
   logic [PTR_W-1:0]  tail_q,  tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   // Combinational helpers
   logic [1:0]        n_req_s;
   logic [1:0]        n_alloc_s;
   logic [1:0]        n_free_s;
   logic              grant_s;
   logic [PTR_W-1:0]  head_p1_s;
   logic              rel_v1_s;
   logic              rel_v2_s;
   logic              acc1_s;
   logic              acc2_s;
   logic              drop_s;
   logic [SPC_W-1:0]  space_s;
   logic [PTR_W-1:0]  wr2_ptr_s;

   // Allocation side: grant decision and compacted head reads.
   always_comb begin
      n_req_s   = {1'b0, alloc_req_1_i} + {1'b0, alloc_req_2_i};
      grant_s   = ({{(CNT_W-2){1'b0}}, n_req_s} <= count_q);
      n_alloc_s = 2'd0;
      if (grant_s) begin
         n_alloc_s = n_req_s;
      end else begin
         n_alloc_s = 2'd0;
      end
      head_p1_s      = ptr_add(head_q, 2'd1);
      alloc_preg_1_o = entry_q[head_q];
      // Slot 2 reads the second entry only when slot 1 is consuming the first.
      if (alloc_req_1_i) begin
         alloc_preg_2_o = entry_q[head_p1_s];
      end else begin
         alloc_preg_2_o = entry_q[head_q];
      end
      alloc_grant_o = grant_s;
   end

   // Release side: validity, room check (slot 2 dropped first) and next state.
   always_comb begin
      rel_v1_s = retire_flag_1_i && (fp_ind_1_i != 6'd0);
      rel_v2_s = retire_flag_2_i && (fp_ind_2_i != 6'd0);
      // Room left after this cycle's allocation has vacated its entries.
      space_s  = SPC_DEPTH - {1'b0, count_q} + {{(SPC_W-2){1'b0}}, n_alloc_s};
      acc1_s   = rel_v1_s && (space_s >= SPC_ONE);
      if (acc1_s) begin
         acc2_s    = rel_v2_s && (space_s >= SPC_TWO);
         wr2_ptr_s = ptr_add(tail_q, 2'd1);
      end else begin
         acc2_s    = rel_v2_s && (space_s >= SPC_ONE);
         wr2_ptr_s = tail_q;
      end
      drop_s     = (rel_v1_s && !acc1_s) || (rel_v2_s && !acc2_s);
      n_free_s   = {1'b0, acc1_s} + {1'b0, acc2_s};
      head_d     = ptr_add(head_q, n_alloc_s);
      tail_d     = ptr_add(tail_q, n_free_s);
      count_d    = count_q - {{(CNT_W-2){1'b0}}, n_alloc_s}
                           + {{(CNT_W-2){1'b0}}, n_free_s};
      overflow_d = overflow_q | drop_s;
   end

   // State registers, FIFO writes and reset image x_n -> p_n.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         count_q    <= CNT_W'(DEPTH);
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= PREG_W'(NUM_AREGS + i);
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         // When full, tail equals head, so writes land in entries just vacated.
         if (acc1_s) begin
            entry_q[tail_q] <= fp_ind_1_i;
         end
         if (acc2_s) begin
            entry_q[wr2_ptr_s] <= fp_ind_2_i;
         end
      end
   end

   assign free_count_o    = count_q;
   assign free_overflow_o = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

   localparam int DEPTH = 32;

   logic       clk;
   logic       rst;
   logic       req1, req2;
   logic       grant;
   logic [5:0] preg1, preg2;
   logic       rf1, rf2;
   logic [5:0] fp1, fp2;
   logic [5:0] fcount;
   logic       fovf;

   int n_checks;
   int n_errors;

   // reference model: the free pool as a plain ordered queue
   int m_q[$];
   bit m_ovf;

   phys_reg_free_list dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .alloc_req_1_i   (req1),
      .alloc_req_2_i   (req2),
      .alloc_grant_o   (grant),
      .alloc_preg_1_o  (preg1),
      .alloc_preg_2_o  (preg2),
      .retire_flag_1_i (rf1),
      .fp_ind_1_i      (fp1),
      .retire_flag_2_i (rf2),
      .fp_ind_2_i      (fp2),
      .free_count_o    (fcount),
      .free_overflow_o (fovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r1, r2, f1;
      logic [5:0] i1;
      logic       f2;
      logic [5:0] i2;
      int         egrant, ep1, ep2, ecnt, eovf;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive one cycle's inputs while clk is low; the following rising edge consumes them
   task automatic set_in(input logic a1, input logic a2, input logic f1v, input logic [5:0] i1,
                         input logic f2v, input logic [5:0] i2);
      @(negedge clk);
      req1 = a1; req2 = a2; rf1 = f1v; fp1 = i1; rf2 = f2v; fp2 = i2;
      #1;
   endtask

   task automatic do_reset(input bit junk);
      @(negedge clk);
      rst = 1'b1;
      if (junk) begin
         req1 = 1'b1; req2 = 1'b1; rf1 = 1'b1; fp1 = 6'd20; rf2 = 1'b1; fp2 = 6'd21;
      end else begin
         req1 = 1'b0; req2 = 1'b0; rf1 = 1'b0; fp1 = 6'd0; rf2 = 1'b0; fp2 = 6'd0;
      end
      @(negedge clk);
      rst = 1'b0;
      req1 = 1'b0; req2 = 1'b0; rf1 = 1'b0; fp1 = 6'd0; rf2 = 1'b0; fp2 = 6'd0;
      #1;
   endtask

   // post-reset image: count 32, pregs 32/33 offered to a dual request, no overflow
   task automatic chk_reset_state(input string tag);
      req1 = 1'b1; req2 = 1'b1;
      #1;
      chk({tag, "_count"}, int'(fcount), 32);
      chk({tag, "_preg1"}, int'(preg1), 32);
      chk({tag, "_preg2"}, int'(preg2), 33);
      chk({tag, "_grant"}, int'(grant), 1);
      chk({tag, "_ovf"},   int'(fovf), 0);
      req1 = 1'b0; req2 = 1'b0;
      #1;
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(32 + i);
      m_ovf = 1'b0;
   endtask

   initial begin
      int nreq;
      int mode;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      req1 = 1'b0; req2 = 1'b0; rf1 = 1'b0; fp1 = 6'd0; rf2 = 1'b0; fp2 = 6'd0;

      // ---------------- scenario 1: reset ----------------
      do_reset(1'b0);
      chk_reset_state("reset");

      // ---------------- table-driven vectors from reset ----------------
      tbl[0] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1, 32, 32, 32, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1, 32, 33, 32, 0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1, 34, 34, 30, 0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0, 1, 35, 36, 29, 0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 6'd7, 1, 36, 36, 29, 0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1, 36, 37, 30, 0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1, 38, 38, 28, 0};
      for (int v = 0; v < 7; v++) begin
         set_in(tbl[v].r1, tbl[v].r2, tbl[v].f1, tbl[v].i1, tbl[v].f2, tbl[v].i2);
         chk($sformatf("vec%0d_grant", v), int'(grant),  tbl[v].egrant);
         chk($sformatf("vec%0d_preg1", v), int'(preg1),  tbl[v].ep1);
         chk($sformatf("vec%0d_preg2", v), int'(preg2),  tbl[v].ep2);
         chk($sformatf("vec%0d_count", v), int'(fcount), tbl[v].ecnt);
         chk($sformatf("vec%0d_ovf",   v), int'(fovf),   tbl[v].eovf);
      end

      // ---------------- scenario 2: drain, then 4: release and wrap ----------------
      do_reset(1'b0);
      for (int k = 0; k < 16; k++) begin
         set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
         chk($sformatf("drain%0d_grant", k), int'(grant), 1);
         chk($sformatf("drain%0d_preg1", k), int'(preg1), 32 + 2*k);
         chk($sformatf("drain%0d_preg2", k), int'(preg2), 33 + 2*k);
      end
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("drain_empty_count", int'(fcount), 0);
      chk("drain_empty_grant", int'(grant), 0);
      set_in(1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 6'd7);
      chk("drain_hold_count", int'(fcount), 0);
      // head must not have moved on the denied request: 5 and 7 appear at the head
      set_in(1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0);
      chk("rel57_count", int'(fcount), 2);
      chk("rel57_preg1", int'(preg1), 5);
      chk("rel57_preg2", int'(preg2), 7);
      chk("rel57_grant", int'(grant), 1);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0);
      chk("p0_drop_count", int'(fcount), 0);
      chk("p0_drop_ovf", int'(fovf), 0);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("p0_drop2_count", int'(fcount), 0);

      // ---------------- scenario 3: partial ----------------
      do_reset(1'b0);
      for (int k = 0; k < 15; k++) set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("partial_single_preg1", int'(preg1), 62);
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("partial_count1", int'(fcount), 1);
      chk("partial_dual_grant", int'(grant), 0);
      set_in(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("partial_slot2_grant", int'(grant), 1);
      chk("partial_slot2_preg2", int'(preg2), 63);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("partial_count0", int'(fcount), 0);

      // ---------------- scenario 5: full boundary ----------------
      do_reset(1'b0);
      set_in(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 6'd0);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("full_ovf_set", int'(fovf), 1);
      chk("full_ovf_count", int'(fcount), 32);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("full_ovf_sticky", int'(fovf), 1);
      do_reset(1'b0);
      chk("full_ovf_cleared", int'(fovf), 0);
      set_in(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 6'd10);
      chk("swap_grant", int'(grant), 1);
      chk("swap_preg1", int'(preg1), 32);
      chk("swap_preg2", int'(preg2), 33);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("swap_count", int'(fcount), 32);
      chk("swap_ovf", int'(fovf), 0);
      for (int k = 0; k < 15; k++) begin
         set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
         chk($sformatf("swap_drain%0d_preg1", k), int'(preg1), 34 + 2*k);
         chk($sformatf("swap_drain%0d_preg2", k), int'(preg2), 35 + 2*k);
      end
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("swap_ret_preg1", int'(preg1), 9);
      chk("swap_ret_preg2", int'(preg2), 10);

      // ---------------- scenario 6: mid-operation reset ----------------
      do_reset(1'b0);
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      set_in(1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 6'd12);
      set_in(1'b1, 1'b0, 1'b1, 6'd13, 1'b0, 6'd0);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("mid_count_before", int'(fcount), 30);
      do_reset(1'b1);
      chk_reset_state("midreset");

      // ---------------- randomized run against the queue model ----------------
      do_reset(1'b0);
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         logic a1, a2, f1v, f2v;
         logic [5:0] i1, i2;
         mode = (c / 150) % 3;
         if (($urandom % 300) == 0) begin
            do_reset(($urandom % 2) == 1);
            model_reset();
         end
         a1  = ($urandom_range(0, 99) < ((mode == 1) ? 80 : (mode == 2) ? 20 : 50));
         a2  = ($urandom_range(0, 99) < ((mode == 1) ? 80 : (mode == 2) ? 20 : 50));
         f1v = ($urandom_range(0, 99) < ((mode == 2) ? 85 : (mode == 1) ? 25 : 50));
         f2v = ($urandom_range(0, 99) < ((mode == 2) ? 85 : (mode == 1) ? 25 : 50));
         i1  = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         i2  = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         set_in(a1, a2, f1v, i1, f2v, i2);
         nreq = int'(a1) + int'(a2);
         chk("rand_count", int'(fcount), m_q.size());
         chk("rand_ovf",   int'(fovf),   int'(m_ovf));
         chk("rand_grant", int'(grant),  (m_q.size() >= nreq) ? 1 : 0);
         if (m_q.size() >= 1) chk("rand_preg1", int'(preg1), m_q[0]);
         if (m_q.size() >= (a1 ? 2 : 1)) chk("rand_preg2", int'(preg2), a1 ? m_q[1] : m_q[0]);
         // the edge: allocate first, then append valid releases in slot order
         if (m_q.size() >= nreq) begin
            for (int n = 0; n < nreq; n++) void'(m_q.pop_front());
         end
         if (f1v && i1 != 6'd0) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(i1));
            else m_ovf = 1'b1;
         end
         if (f2v && i2 != 6'd0) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(i2));
            else m_ovf = 1'b1;
         end
      end
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("rand_final_count", int'(fcount), m_q.size());
      chk("rand_final_ovf", int'(fovf), int'(m_ovf));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
